// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//
// Purpose:
//   Four-way round-robin arbiter fused with a 4:1 data multiplexer and a
//   one-entry registered output stage. Each cycle the output register can
//   take a new word (when empty or being drained). When it can, one valid
//   requester is granted. The grant is chosen by searching from the requester
//   after the last one granted. The granted word reaches out_data on the next
//   rising edge.
//
// Ports:
//   clk        in   1      single clock, rising-edge
//   rst        in   1      synchronous active-high reset
//   d0..d3     in   WIDTH  requester data channels 0..3
//   req_valid  in   4      bit i: requester i presents data
//   req_ready  out  4      bit i: requester i transfers this cycle (comb.)
//   out_ready  in   1      downstream accepts out_data this cycle
//   out_valid  out  1      registered: out_data holds a valid word
//   out_data   out  WIDTH  registered selected data word
//   out_sel    out  2      registered index of the source of out_data
//
// Configuration:
//   RR_MUX_PRIORITY0_EN  when defined, requester 0 wins whenever it is
//                        valid. Requesters 1..3 share the remaining cycles
//                        round-robin. The pointer only tracks grants to 1..3.
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [3:0]       req_valid,
    output logic [3:0]       req_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);

    // Round-robin pointer: index of the most recently granted requester.
    // It resets to 3 so the first search starts at requester 0.
    logic [1:0]       last_grant;

    // The output register can accept a word when it is empty or is being
    // drained during the same cycle.
    logic             load_en;

    // Arbitration results for the current cycle.
    logic [3:0]       grant;
    logic [1:0]       grant_idx;
    logic             grant_any;
    logic [WIDTH-1:0] sel_data;

    assign load_en = !out_valid || out_ready;

`ifdef RR_MUX_PRIORITY0_EN
    // Requester 0 preempts the rotation. When it is absent, the rotation
    // runs over 1..3 only. Bit 0 is masked out, and the pointer is never
    // left at 0 by a priority grant.
    logic [3:0] rr_valid;
    logic [1:0] rr_idx;
    logic       rr_any;

    assign rr_valid = {req_valid[3:1], 1'b0};

    always_comb begin
        rr_idx = 2'd0;
        rr_any = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!rr_any && rr_valid[last_grant + 2'(k)]) begin
                rr_idx = last_grant + 2'(k);
                rr_any = 1'b1;
            end
        end
    end

    always_comb begin
        if (req_valid[0]) begin
            grant_idx = 2'd0;
            grant_any = 1'b1;
        end else begin
            grant_idx = rr_idx;
            grant_any = rr_any;
        end
    end
`else
    // Plain round-robin: the search visits last_grant+1, +2, +3 and +4,
    // modulo 4, and stops at the first requester presenting data.
    // The 2-bit wraparound provides the modulo for free.
    always_comb begin
        grant_idx = 2'd0;
        grant_any = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!grant_any && req_valid[last_grant + 2'(k)]) begin
                grant_idx = last_grant + 2'(k);
                grant_any = 1'b1;
            end
        end
    end
`endif

    // Expand the encoded winner to a one-hot grant vector.
    always_comb begin
        grant = 4'b0000;
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Ready is only offered when the output register can take the word, and
    // never during reset, so a reset cycle reports no transfer.
    always_comb begin
        req_ready = 4'b0000;
        if (!rst && load_en) begin
            req_ready = grant;
        end
    end

    // Data steering: a plain 4:1 selection indexed by the encoded grant.
    always_comb begin
        case (grant_idx)
            2'd0:    sel_data = d0;
            2'd1:    sel_data = d1;
            2'd2:    sel_data = d2;
            default: sel_data = d3;
        endcase
    end

    // Output register and pointer. When the register is stalled, state is
    // frozen and req_valid is ignored. When it can load but nobody
    // requests, it empties while keeping the last data, sel and pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= 2'd0;
            last_grant <= 2'd3;
        end else if (load_en) begin
            if (grant_any) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_sel   <= grant_idx;
`ifdef RR_MUX_PRIORITY0_EN
                if (grant_idx != 2'd0) begin
                    last_grant <= grant_idx;
                end
`else
                last_grant <= grant_idx;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter
//
// Testbench for rr_mux_arbiter. It drives directed scenarios followed by
// random traffic. Every cycle it compares req_ready and the registered
// outputs against a behavioural model of the arbitration rules. The model
// holds the output register contents and the last granted index as plain
// integers.
// ---------------------------------------------------------------------------
module tb_rr_mux_arbiter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    int m_valid = 0;
    int m_data  = 0;
    int m_sel   = 0;
    int m_last  = 3;

    rr_mux_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the model's expectation.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of stimulus. Inputs change on the falling edge.
    // req_ready is checked before the rising edge. The registered outputs
    // are checked just after it.
    task automatic applyStimulus(input logic r, input logic [3:0] rv, input logic ordy,
                                 input int a, input int b, input int c, input int e);
        int  dv[4];
        int  exp_ready;
        int  win;
        bit  can_load;
        @(negedge clk);
        rst       = r;
        req_valid = rv;
        out_ready = ordy;
        d0 = WIDTH'(a); d1 = WIDTH'(b); d2 = WIDTH'(c); d3 = WIDTH'(e);
        dv[0] = a % 16; dv[1] = b % 16; dv[2] = c % 16; dv[3] = e % 16;

        // The output register can load when empty or when being drained.
        // Requesters are searched starting one past the last winner.
        can_load  = (m_valid == 0) || ordy;
        win       = -1;
        exp_ready = 0;
        if (!r && can_load) begin
`ifdef RR_MUX_PRIORITY0_EN
            if (rv[0]) win = 0;
`endif
            for (int k = 1; k <= 4 && win < 0; k++) begin
                if (rv[(m_last + k) % 4]) win = (m_last + k) % 4;
            end
            if (win >= 0) exp_ready = 1 << win;
        end
        #1;
        checkOutput("req_ready", int'(req_ready), exp_ready);

        if (r) begin
            m_valid = 0; m_data = 0; m_sel = 0; m_last = 3;
        end else if (can_load) begin
            if (win >= 0) begin
                m_valid = 1; m_data = dv[win]; m_sel = win;
`ifdef RR_MUX_PRIORITY0_EN
                if (win != 0) m_last = win;
`else
                m_last = win;
`endif
            end else begin
                m_valid = 0;
            end
        end

        @(posedge clk);
        #1;
        checkOutput("out_valid", int'(out_valid), m_valid);
        checkOutput("out_data",  int'(out_data),  m_data);
        checkOutput("out_sel",   int'(out_sel),   m_sel);
    endtask

    initial begin
        rst = 1'b1; req_valid = 4'b0; out_ready = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        $display("[TB] starting rr_mux_arbiter bench");

        // Reset state.
        applyStimulus(1'b1, 4'b0000, 1'b0, 0, 0, 0, 0);
        applyStimulus(1'b1, 4'b1111, 1'b1, 1, 2, 3, 4);

        // All four requesters continuously: rotation 0,1,2,3,0,...
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'b1111, 1'b1, 1, 2, 3, 4);

        // Only requester 2 is valid.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b0100, 1'b1, 7, 8, 10, 9);

        // Load a 5 from requester 3, then stall while everyone requests.
        applyStimulus(1'b0, 4'b1000, 1'b1, 1, 2, 3, 5);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1111, 1'b0, 1, 2, 3, 4);
        applyStimulus(1'b0, 4'b0110, 1'b0, 1, 2, 3, 4);
        applyStimulus(1'b0, 4'b1111, 1'b1, 1, 2, 3, 4);

        // Get requester 1 into the output register, then reset mid-stream.
        applyStimulus(1'b0, 4'b0010, 1'b1, 6, 7, 8, 9);
        applyStimulus(1'b1, 4'b1111, 1'b0, 6, 7, 8, 9);
        applyStimulus(1'b0, 4'b1111, 1'b1, 6, 7, 8, 9);

        // All requests drop while draining: out_valid clears, sel holds.
        applyStimulus(1'b0, 4'b0100, 1'b1, 1, 2, 3, 4);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1, 2, 3, 4);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1, 2, 3, 4);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 31) == 0), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: width of each data input and of out_data.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 d0, d1, d2, d3  input  WIDTH each  requester data channels 0..3.
REQ-005 req_valid  input  4  bit i = requester i has data on di.
REQ-006 req_ready  output  4  bit i = requester i transfers this cycle; combinational.
REQ-007 out_ready  input  1  downstream accepts out_data this cycle.
REQ-008 out_valid  output  1  registered; out_data holds a valid word.
REQ-009 out_data  output  WIDTH  registered selected data word.
REQ-010 out_sel  output  2  registered index of the requester whose word sits in out_data.

Function
REQ-011 The block SHALL hold an internal 2-bit round-robin pointer last_grant and a one-entry output register (out_valid, out_data, out_sel).
REQ-012 load_en SHALL be (!out_valid | out_ready), so the output register accepts a new word when it is empty or is being drained in the same cycle.
REQ-013 The grant SHALL be one-hot over the requesters with req_valid set, searched in order last_grant+1, +2, +3, +4 (mod 4); the first match wins.
REQ-014 req_ready SHALL equal grant when load_en=1 and SHALL be 4'b0000 when load_en=0; at most one bit SHALL ever be set.
REQ-015 A transfer from requester i SHALL occur when req_valid[i] & req_ready[i].
REQ-016 On a transfer, the next edge SHALL set out_valid=1, out_data=di (sampled that cycle), out_sel=i and last_grant=i, giving 1-cycle latency.
REQ-017 When load_en=1 and no req_valid bit is set, the next edge SHALL clear out_valid; out_data, out_sel and last_grant SHALL hold.
REQ-018 When out_valid=1 and out_ready=0, out_valid, out_data and out_sel SHALL hold unchanged and req_ready SHALL be 0.
REQ-019 Throughput SHALL be one word per cycle under continuous out_ready=1 with any requester active.
REQ-020 If only requester i is valid, it SHALL be granted every eligible cycle regardless of last_grant.
REQ-021 Under continuous request from all four requesters, grants SHALL rotate 0,1,2,3,0,... after reset, with no requester waiting more than 3 transfers.
REQ-022 req_valid changing while the block is stalled (REQ-018) SHALL NOT affect state, and SHALL only be evaluated when load_en=1.
REQ-023 Data inputs SHALL be steered through a 4:1 selection indexed by the encoded grant; no arithmetic is performed on data.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL set out_valid=0, out_data=0, out_sel=2'd0 and last_grant=2'd3, so requester 0 has first priority after reset.
REQ-025 req_ready SHALL be 4'b0000 during any cycle with rst=1.
REQ-026 Reset asserted mid-stream SHALL discard the held output word with no transfer reported, and no req_ready SHALL be issued in that cycle.

Configuration
REQ-027 With macro RR_MUX_PRIORITY0_EN defined, requester 0 SHALL be granted whenever req_valid[0]=1 and load_en=1, overriding round-robin.
REQ-028 Under RR_MUX_PRIORITY0_EN, requesters 1..3 SHALL arbitrate round-robin among themselves only when req_valid[0]=0, and last_grant SHALL update only on grants to 1..3.
REQ-029 Without RR_MUX_PRIORITY0_EN, all four requesters SHALL be equal under REQ-013, and no extra logic SHALL be present.

Verification
REQ-030 Reset, then req_valid=4'b1111 with d0..d3=1,2,3,4 and out_ready=1 held for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, out_data 1,2,3,4,... and out_valid=1 from the 2nd edge.
REQ-031 Only req_valid[2]=1 with d2=4'hA, out_ready=1 -> req_ready=4'b0100 every cycle, and out_data=4'hA with out_sel=2 one cycle later.
REQ-032 out_valid=1 holding 4'h5 with out_ready=0 for 3 cycles while req_valid=4'b1111 -> req_ready=0 and out_data=4'h5 stable; on out_ready=1, the next requester in rotation is granted that same cycle.
REQ-033 Assert rst for 1 cycle while out_valid=1 and out_sel=1 -> next cycle out_valid=0, out_data=0; the first grant afterwards goes to requester 0 when all requesters are valid.
REQ-034 All requests drop while out_ready=1 -> out_valid=0 after one edge, and out_sel holds its last value.
REQ-035 With RR_MUX_PRIORITY0_EN defined, req_valid=4'b1111 and out_ready=1 -> out_sel=0 every cycle; with req_valid=4'b1110 -> out_sel rotates 1,2,3.
